coherence_bus_ctrl: RTL and testbench

COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/bus_arbiter.sv | 33 +++
 rtl/coherence_bus_ctrl.sv | 154 +++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side bus types: data word, RAM handshake state and the coherence bus FSM states.
package cpu_types_pkg;

  localparam int CPUS   = 2;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SNOOP  = 3'd1,
    XFER1  = 3'd2,
    XFER2  = 3'd3,
    RAMRD1 = 3'd4,
    RAMRD2 = 3'd5,
    RAMWR1 = 3'd6,
    RAMWR2 = 3'd7
  } busstate_t;

endpackage

// File: rtl/bus_arbiter.sv
// Picks which cache owns the next bus transaction.
// Define BUS_RR_ARB_EN for round-robin on simultaneous requests; otherwise cache 0 always wins.
module bus_arbiter
  import cpu_types_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic [CPUS-1:0] req,
  input  logic            txn_done,
  output logic            grant
);

`ifdef BUS_RR_ARB_EN
  logic rr_ptr;

  // The pointer flips on every return to IDLE, so the loser of a tie goes first next time.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= 1'b0;
    end else if (txn_done) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  assign grant = (&req) ? rr_ptr : req[1];
`else
  logic unused_rr;

  assign unused_rr = CLK ^ RST ^ txn_done;
  assign grant     = req[1] & ~req[0];
`endif

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Responder end of a two-cache coherence bus: serves misses, writebacks and snoops one at a time.
// Arbitration mode is selected by the BUS_RR_ARB_EN macro inside bus_arbiter.
module coherence_bus_ctrl #(
  parameter int CPUS = 2
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [CPUS-1:0]                    dREN,
  input  logic [CPUS-1:0]                    dWEN,
  input  logic [CPUS-1:0]                    ccwrite,
  input  logic [CPUS-1:0]                    cctrans,
  input  cpu_types_pkg::word_t [CPUS-1:0]    daddr,
  input  cpu_types_pkg::word_t [CPUS-1:0]    dstore,
  output logic [CPUS-1:0]                    dwait,
  output cpu_types_pkg::word_t [CPUS-1:0]    dload,
  output logic [CPUS-1:0]                    ccwait,
  output logic [CPUS-1:0]                    ccinv,
  output cpu_types_pkg::word_t [CPUS-1:0]    ccsnoopaddr,
  output logic                               ramREN,
  output logic                               ramWEN,
  output cpu_types_pkg::word_t               ramaddr,
  output cpu_types_pkg::word_t               ramstore,
  input  cpu_types_pkg::word_t               ramload,
  input  cpu_types_pkg::ramstate_t           ramstate
);

  import cpu_types_pkg::*;

  busstate_t       state, next_state;
  logic            gnt_q;
  logic            arb_gnt;
  logic            g, o;
  logic [CPUS-1:0] req;
  logic            txn_done;
  logic            snoop_on;
  logic            abort;
  logic            ram_ok;

  assign req      = dREN | dWEN;
  assign g        = gnt_q;
  assign o        = ~gnt_q;
  assign txn_done = (state != IDLE) && (next_state == IDLE);
  assign snoop_on = (state == SNOOP) || (state == XFER1) || (state == XFER2) ||
                    (state == RAMRD1) || (state == RAMRD2);
  assign abort    = !dREN[g] && !dWEN[g];
  assign ram_ok   = (ramstate == ACCESS);

  bus_arbiter u_arb (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req),
    .txn_done (txn_done),
    .grant    (arb_gnt)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gnt_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && |req) begin
        gnt_q <= arb_gnt;
      end
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    next_state  = state;
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    if (snoop_on) begin
      ccwait[o]      = 1'b1;
      ccsnoopaddr[o] = daddr[g];
      ccinv[o]       = ccwrite[g];
    end

    case (state)
      IDLE: begin
        // ccwait is always low in IDLE, so any write request here is a plain writeback.
        if (|req) begin
          next_state = dWEN[arb_gnt] ? RAMWR1 : SNOOP;
        end
      end

      SNOOP: begin
        next_state = dWEN[o] ? XFER1 : RAMRD1;
      end

      XFER1, XFER2: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[o];
          ramstore = dstore[o];
          dload[g] = dstore[o];
          if (ram_ok) begin
            dwait[g]   = 1'b0;
            dwait[o]   = 1'b0;
            next_state = (state == XFER1) ? XFER2 : IDLE;
          end
        end
      end

      RAMRD1, RAMRD2: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          ramREN   = 1'b1;
          ramaddr  = daddr[g];
          dload[g] = ramload;
          dwait[g] = !ram_ok;
          if (ram_ok) begin
            next_state = (state == RAMRD1) ? RAMRD2 : IDLE;
          end
        end
      end

      RAMWR1, RAMWR2: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[g];
          ramstore = dstore[g];
          dwait[g] = !ram_ok;
          if (ram_ok) begin
            next_state = (state == RAMWR1) ? RAMWR2 : IDLE;
          end
        end
      end

      default: next_state = IDLE;
    endcase
  end

  // A read grant must not land while the peer is mid-way through its own bus transaction.
  a_read_grant_peer_idle : assert property (
    @(posedge CLK) disable iff (RST)
      (state == IDLE && next_state == SNOOP) |-> !(cctrans[~arb_gnt] && req[~arb_gnt])
  );

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: cache and RAM models, expected reads/writes/snoops queued up front.
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  dREN, dWEN, ccwrite, cctrans;
  word_t [1:0] daddr, dstore, dload, ccsnoopaddr;
  logic [1:0]  dwait, ccwait, ccinv;
  logic        ramREN, ramWEN;
  word_t       ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  coherence_bus_ctrl #(.CPUS(2)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite), .cctrans(cctrans),
    .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // RAM model: contents are a fixed function of the address; BUSY for busy_left accessed cycles.
  function automatic word_t ram_word(input word_t a);
    return a ^ 32'h5A5A_0000;
  endfunction

  int busy_left = 0;
  assign ramload = ram_word(ramaddr);
  always_comb begin
    if (!(ramREN || ramWEN)) ramstate = FREE;
    else if (busy_left > 0)  ramstate = BUSY;
    else                     ramstate = ACCESS;
  end

  typedef struct {
    logic  wr;
    logic  inv;
    word_t addr;
    word_t data;
  } txn_t;

  txn_t        txq0[$], txq1[$];
  word_t       exp_rd0[$], exp_rd1[$];
  logic [63:0] exp_wr[$];
  logic [33:0] exp_snp[$];

  txn_t     cur[2];
  bit [1:0] act;
  int       words[2];
  bit [1:0] dirty;
  word_t    dirty_addr[2];
  word_t    dirty_data[2];
  bit       mon_en;
  logic [1:0] prev_ccwait;
  int       lat;
  int       busy_seen;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dwait"}, dwait, 2'b11);
    check({tag, "_dload"}, dload, 64'h0);
    check({tag, "_ccwait_inv"}, {ccwait, ccinv}, 4'h0);
    check({tag, "_snoopaddr"}, ccsnoopaddr, 64'h0);
    check({tag, "_ram_strobes"}, {ramREN, ramWEN}, 2'b00);
    check({tag, "_ramaddr"}, ramaddr, 32'h0);
    check({tag, "_ramstore"}, ramstore, 32'h0);
  endtask

  task automatic start_next(input int c);
    if (c == 0 && txq0.size() > 0) begin
      cur[0] = txq0.pop_front(); act[0] = 1'b1; words[0] = 0;
    end else if (c == 1 && txq1.size() > 0) begin
      cur[1] = txq1.pop_front(); act[1] = 1'b1; words[1] = 0;
    end
  endtask

  task automatic drive();
    for (int c = 0; c < 2; c++) begin
      dREN[c]    = act[c] && !cur[c].wr;
      dWEN[c]    = act[c] && cur[c].wr;
      ccwrite[c] = act[c] && !cur[c].wr && cur[c].inv;
      daddr[c]   = act[c] ? cur[c].addr : '0;
      dstore[c]  = (act[c] && cur[c].wr) ? cur[c].data : '0;
    end
  endtask

  task automatic read_word(input int c);
    word_t e;
    int    n;
    n = (c == 0) ? exp_rd0.size() : exp_rd1.size();
    if (n == 0) begin
      check($sformatf("rd_q%0d_avail", c), n, 1);
    end else begin
      if (c == 0) e = exp_rd0.pop_front();
      else        e = exp_rd1.pop_front();
      check($sformatf("dload%0d", c), dload[c], e);
    end
    check($sformatf("read_latency%0d", c), lat, words[c] + 2);
  endtask

  task automatic monitor();
    logic [1:0]  rise;
    logic [63:0] ew;
    logic [33:0] es;
    rise = ccwait & ~prev_ccwait;
    prev_ccwait = ccwait;
    if (!mon_en) return;
    lat++;
    for (int c = 0; c < 2; c++) begin
      if (rise[c]) begin
        if (exp_snp.size() == 0) begin
          check("snoop_q_avail", exp_snp.size(), 1);
        end else begin
          es = exp_snp.pop_front();
          check("snoop", {1'(c), ccsnoopaddr[c], ccinv[c]}, es);
        end
        lat = 1;
      end
    end
    if (ramWEN && ramstate == ACCESS) begin
      if (exp_wr.size() == 0) begin
        check("wr_q_avail", exp_wr.size(), 1);
      end else begin
        ew = exp_wr.pop_front();
        check("ram_write", {ramaddr, ramstore}, ew);
      end
    end
    if (ramWEN && dwait[1] && act[1] && cur[1].wr) busy_seen++;
    for (int c = 0; c < 2; c++) begin
      if (act[c] && dwait[c] == 1'b0) begin
        if (!cur[c].wr) read_word(c);
        words[c]++;
        cur[c].addr += 32'd4;
        cur[c].data += 32'd1;
        if (words[c] == 2) begin
          act[c] = 1'b0;
          start_next(c);
        end
      end else if (!act[c]) begin
        check($sformatf("idle_dwait%0d", c), dwait[c], 1'b1);
        check($sformatf("idle_dload%0d", c), dload[c], 32'h0);
        // A dirty cache answers a snoop by supplying its line.
        if (ccwait[c] && dirty[c]) begin
          cur[c]   = '{wr: 1'b1, inv: 1'b0, addr: dirty_addr[c], data: dirty_data[c]};
          act[c]   = 1'b1;
          words[c] = 0;
          dirty[c] = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    logic ram_active;
    @(negedge CLK);
    ram_active = ramREN || ramWEN;
    monitor();
    if (mon_en) drive();
    if (ram_active && busy_left > 0) busy_left--;
  endtask

  task automatic run_model(input string tag, input int max_cycles);
    bit done;
    done   = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 2; c++) if (!act[c]) start_next(c);
    drive();
    for (int i = 0; i < max_cycles && !done; i++) begin
      cycle();
      done = !act[0] && !act[1] && txq0.size() == 0 && txq1.size() == 0;
    end
    check({tag, "_completed"}, done, 1'b1);
    repeat (2) cycle();
    check({tag, "_leftover"},
          exp_rd0.size() + exp_rd1.size() + exp_wr.size() + exp_snp.size(), 0);
    mon_en = 1'b0;
  endtask

  task automatic clear_inputs();
    dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0; daddr = '0; dstore = '0;
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    act = '0; dirty = '0;
    clear_inputs();
    RST = 1'b1;
    repeat (2) cycle();
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mon_en = 1'b0; act = '0; dirty = '0; prev_ccwait = '0; lat = 0; busy_seen = 0;
    clear_inputs();
    RST = 1'b1;
    repeat (3) cycle();
    check_idle_outputs("reset_hold");
    RST = 1'b0;
    cycle();
    check_idle_outputs("post_reset");

    // Clean read miss from core0.
    txq0.push_back('{wr: 1'b0, inv: 1'b0, addr: 32'h100, data: 32'h0});
    exp_rd0.push_back(ram_word(32'h100));
    exp_rd0.push_back(ram_word(32'h104));
    exp_snp.push_back({1'b1, 32'h100, 1'b0});
    run_model("read_clean", 50);

    // Core1 holds the line dirty; core0 reads for ownership, so core1 supplies and RAM is updated.
    dirty[1] = 1'b1; dirty_addr[1] = 32'h100; dirty_data[1] = 32'hC0DE_0000;
    txq0.push_back('{wr: 1'b0, inv: 1'b1, addr: 32'h100, data: 32'h0});
    exp_rd0.push_back(32'hC0DE_0000);
    exp_rd0.push_back(32'hC0DE_0001);
    exp_snp.push_back({1'b1, 32'h100, 1'b1});
    exp_wr.push_back({32'h100, 32'hC0DE_0000});
    exp_wr.push_back({32'h104, 32'hC0DE_0001});
    run_model("read_dirty", 50);

    // Read miss from core1 with invalidate.
    txq1.push_back('{wr: 1'b0, inv: 1'b1, addr: 32'h340, data: 32'h0});
    exp_rd1.push_back(ram_word(32'h340));
    exp_rd1.push_back(ram_word(32'h344));
    exp_snp.push_back({1'b0, 32'h340, 1'b1});
    run_model("read_core1", 50);

    // Writeback from core1 against a RAM that is BUSY for three cycles.
    busy_left = 3; busy_seen = 0;
    txq1.push_back('{wr: 1'b1, inv: 1'b0, addr: 32'h200, data: 32'hB0B0_0000});
    exp_wr.push_back({32'h200, 32'hB0B0_0000});
    exp_wr.push_back({32'h204, 32'hB0B0_0001});
    run_model("wb_busy", 50);
    check("wb_busy_cycles", busy_seen, 3);

    // Writeback abandoned while the RAM is still busy: no write, straight back to IDLE.
    busy_left = 5;
    dWEN[0] = 1'b1; daddr[0] = 32'h600; dstore[0] = 32'h1234_5678;
    cycle();
    check("abort_pre_ramWEN", ramWEN, 1'b1);
    check("abort_pre_dwait", dwait, 2'b11);
    dWEN[0] = 1'b0;
    #1;
    check("abort_no_access", {ramREN, ramWEN}, 2'b00);
    cycle();
    check_idle_outputs("abort_idle");
    busy_left = 0;
    clear_inputs();

    // Two contention rounds: core0 issues back-to-back reads while core1 waits.
    apply_reset();
    txq0.push_back('{wr: 1'b0, inv: 1'b0, addr: 32'h400, data: 32'h0});
    txq0.push_back('{wr: 1'b0, inv: 1'b0, addr: 32'h408, data: 32'h0});
    txq1.push_back('{wr: 1'b0, inv: 1'b0, addr: 32'h500, data: 32'h0});
    exp_rd0.push_back(ram_word(32'h400)); exp_rd0.push_back(ram_word(32'h404));
    exp_rd0.push_back(ram_word(32'h408)); exp_rd0.push_back(ram_word(32'h40C));
    exp_rd1.push_back(ram_word(32'h500)); exp_rd1.push_back(ram_word(32'h504));
    exp_snp.push_back({1'b1, 32'h400, 1'b0});
`ifdef BUS_RR_ARB_EN
    exp_snp.push_back({1'b0, 32'h500, 1'b0});
    exp_snp.push_back({1'b1, 32'h408, 1'b0});
`else
    exp_snp.push_back({1'b1, 32'h408, 1'b0});
    exp_snp.push_back({1'b0, 32'h500, 1'b0});
`endif
    run_model("contention", 100);

    // Reset arriving during the second word of a read miss.
    dREN[0] = 1'b1; daddr[0] = 32'h700;
    cycle();
    check("rst_snoop_ccwait", ccwait, 2'b10);
    cycle();
    check("rst_rd1_dwait", dwait[0], 1'b0);
    check("rst_rd1_dload", dload[0], ram_word(32'h700));
    daddr[0] = 32'h704;
    cycle();
    check("rst_rd2_ram", {ramREN, ramaddr}, {1'b1, 32'h704});
    RST = 1'b1;
    cycle();
    check_idle_outputs("rst_mid");
    RST = 1'b0;
    clear_inputs();
    cycle();
    check_idle_outputs("rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
